// File: rtl/lc_rf_pkg.sv
// Shared types and defaults for the layer-controller register file.
// Holds handshake state encodings and the default register width.
`ifndef LC_RF_DATA_WIDTH
`define LC_RF_DATA_WIDTH 20
`endif

package lc_rf_pkg;

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_e;

  localparam int LC_RF_DW = `LC_RF_DATA_WIDTH;

endpackage

// File: rtl/lc_rf_hs_port.sv
// Four-phase REQ/ACK handshake FSM for one register-file port.
// exec fires once per request; done marks the edge that drops ACK.
module lc_rf_hs_port
  import lc_rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic ack,
  output logic exec,
  output logic done
);

  hs_state_e state;
  hs_state_e state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HS_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HS_IDLE: if (req)  state_nxt = HS_ACK;
      HS_ACK:  if (!req) state_nxt = HS_IDLE;
    endcase
  end

  always_comb begin
    ack  = (state == HS_ACK);
    exec = (state == HS_IDLE) && req;
    done = (state == HS_ACK) && !req;
  end

endmodule

// File: rtl/lc_rf_bank.sv
// Clocked layer-controller register file with REQ/ACK write and read
// ports, read-only ROM entries, error flags and per-entry load pulses.
module lc_rf_bank
  import lc_rf_pkg::*;
#(
  parameter int                  RF_DEPTH   = 128,
  parameter int                  DATA_WIDTH = LC_RF_DW,
  parameter int                  ADDR_WIDTH = 8,
  parameter logic [RF_DEPTH-1:0] RO_MASK    = '0
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           WR_REQ,
  input  logic [ADDR_WIDTH-1:0]          WR_ADDR,
  input  logic [DATA_WIDTH-1:0]          WR_DATA,
  output logic                           WR_ACK,
  output logic                           WR_ERR,
  input  logic                           RD_REQ,
  input  logic [ADDR_WIDTH-1:0]          RD_ADDR,
  output logic                           RD_ACK,
  output logic [DATA_WIDTH-1:0]          RD_DATA,
  output logic                           RD_ERR,
  output logic [DATA_WIDTH*RF_DEPTH-1:0] DOUT,
  output logic [RF_DEPTH-1:0]            LOAD_PULSE
);

  if (RF_DEPTH < 1 ||
      (64'(1) << ADDR_WIDTH) < 64'(RF_DEPTH)) begin : g_bad_cfg
    $error("lc_rf_bank: RF_DEPTH must fit in ADDR_WIDTH");
  end

  logic                  wr_exec;
  logic                  wr_done;
  logic                  rd_exec;
  logic                  rd_done;
  logic [RF_DEPTH-1:0]   wr_hit;
  logic [RF_DEPTH-1:0]   rd_hit;
  logic [RF_DEPTH-1:0]   wr_en;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_val;

  lc_rf_hs_port u_wr_port (
    .clk  (CLK),
    .rst  (RESET),
    .req  (WR_REQ),
    .ack  (WR_ACK),
    .exec (wr_exec),
    .done (wr_done)
  );

  lc_rf_hs_port u_rd_port (
    .clk  (CLK),
    .rst  (RESET),
    .req  (RD_REQ),
    .ack  (RD_ACK),
    .exec (rd_exec),
    .done (rd_done)
  );

  // One-hot decode doubles as the range check: no hit means out of range.
  for (genvar i = 0; i < RF_DEPTH; i++) begin : g_ent
    assign wr_hit[i] = (WR_ADDR == ADDR_WIDTH'(i));
    assign rd_hit[i] = (RD_ADDR == ADDR_WIDTH'(i));
    assign wr_en[i]  = wr_exec & wr_hit[i] & ~RO_MASK[i];

    if (RO_MASK[i]) begin : g_ro
      assign DOUT[DATA_WIDTH*i +: DATA_WIDTH] = DATA_WIDTH'(i);
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;

      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)         q <= '0;
        else if (wr_en[i]) q <= WR_DATA;
      end

      assign DOUT[DATA_WIDTH*i +: DATA_WIDTH] = q;
    end
  end

  assign wr_ok = |(wr_hit & ~RO_MASK);
  assign rd_ok = |rd_hit;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < RF_DEPTH; i++) begin
      if (rd_hit[i]) rd_val = DOUT[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WR_ERR     <= 1'b0;
      RD_ERR     <= 1'b0;
      RD_DATA    <= '0;
      LOAD_PULSE <= '0;
    end else begin
      LOAD_PULSE <= wr_en;
      if (wr_exec)      WR_ERR <= !wr_ok;
      else if (wr_done) WR_ERR <= 1'b0;
      if (rd_exec) begin
        RD_ERR  <= !rd_ok;
        RD_DATA <= rd_val;
      end else if (rd_done) begin
        RD_ERR  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lc_rf_bank.sv
// Scoreboard bench for lc_rf_bank: directed handshakes, ROM entries,
// errors, same-edge read/write, mid-handshake reset, random traffic.
module tb_lc_rf_bank;

  localparam int DW = 20;
  localparam int D  = 128;
  localparam int AW = 8;
  localparam logic [D-1:0] RO = D'(1) << 5;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } wr_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } rd_exp_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          WR_REQ = 1'b0;
  logic [AW-1:0] WR_ADDR = '0;
  logic [DW-1:0] WR_DATA = '0;
  logic          RD_REQ = 1'b0;
  logic [AW-1:0] RD_ADDR = '0;

  logic          WR_ACK, WR_ERR, RD_ACK, RD_ERR;
  logic [DW-1:0] RD_DATA;
  logic [DW*D-1:0] DOUT;
  logic [D-1:0]  LOAD_PULSE;

  logic          d0_wr_ack, d0_wr_err, d0_rd_ack, d0_rd_err;
  logic [DW-1:0] d0_rd_data;
  logic [DW*D-1:0] d0_dout;
  logic [D-1:0]  d0_load_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;

  logic [DW-1:0] model [D];
  wr_exp_t wr_q [$];
  rd_exp_t rd_q [$];

  always #5 CLK = ~CLK;

  lc_rf_bank #(
    .RF_DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RO_MASK(RO)
  ) u_dut (
    .CLK(CLK), .RESET(RESET),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_ACK(WR_ACK), .WR_ERR(WR_ERR),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR),
    .RD_ACK(RD_ACK), .RD_DATA(RD_DATA), .RD_ERR(RD_ERR),
    .DOUT(DOUT), .LOAD_PULSE(LOAD_PULSE)
  );

  lc_rf_bank #(
    .RF_DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RO_MASK('0)
  ) u_dut0 (
    .CLK(CLK), .RESET(RESET),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_ACK(d0_wr_ack), .WR_ERR(d0_wr_err),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR),
    .RD_ACK(d0_rd_ack), .RD_DATA(d0_rd_data), .RD_ERR(d0_rd_err),
    .DOUT(d0_dout), .LOAD_PULSE(d0_load_pulse)
  );

  always @(negedge CLK) begin
    if (!RESET) pulse_cnt += $countones(LOAD_PULSE);
  end

  function automatic logic [DW-1:0] ent(input int a);
    return DOUT[a*DW +: DW];
  endfunction

  function automatic logic exp_err(input logic [AW-1:0] a);
    return (int'(a) >= D) || (int'(a) == 5);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < D; i++) model[i] = '0;
    model[5] = DW'(5);
  endfunction

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          input int hold);
    wr_exp_t e;
    logic [D-1:0] ep;
    logic [DW*D-1:0] pre;
    @(negedge CLK);
    WR_REQ = 1'b1; WR_ADDR = a; WR_DATA = d;
    pre = DOUT;
    wr_q.push_back('{addr: a, data: d, err: exp_err(a)});
    @(negedge CLK);
    e = wr_q.pop_front();
    ep = '0;
    if (!e.err) ep[e.addr] = 1'b1;
    checks++;
    if (WR_ACK !== 1'b1) begin
      errors++; $display("FAIL wr_ack a=%0d got %b want 1", a, WR_ACK);
    end
    checks++;
    if (WR_ERR !== e.err) begin
      errors++; $display("FAIL wr_err a=%0d got %b want %b", a, WR_ERR, e.err);
    end
    checks++;
    if (LOAD_PULSE !== ep) begin
      errors++; $display("FAIL load_pulse a=%0d got %h want %h", a, LOAD_PULSE, ep);
    end
    if (e.err) begin
      checks++;
      if (DOUT !== pre) begin
        errors++; $display("FAIL dout_unchanged a=%0d", a);
      end
    end else begin
      model[e.addr] = e.data;
      exp_pulses++;
      checks++;
      if (ent(int'(e.addr)) !== e.data) begin
        errors++;
        $display("FAIL dout_entry a=%0d got %h want %h", a, ent(int'(e.addr)), e.data);
      end
    end
    repeat (hold) begin
      @(negedge CLK);
      checks++;
      if (WR_ACK !== 1'b1 || LOAD_PULSE !== '0) begin
        errors++; $display("FAIL wr_hold a=%0d ack %b pulse %h want 1/0", a, WR_ACK, LOAD_PULSE);
      end
    end
    WR_REQ = 1'b0;
    @(negedge CLK);
    checks++;
    if (WR_ACK !== 1'b0 || WR_ERR !== 1'b0 || LOAD_PULSE !== '0) begin
      errors++;
      $display("FAIL wr_release a=%0d ack %b err %b pulse %h want 0", a, WR_ACK, WR_ERR, LOAD_PULSE);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold);
    rd_exp_t r;
    @(negedge CLK);
    #1;
    RD_REQ = 1'b1; RD_ADDR = a;
    if (int'(a) < D) rd_q.push_back('{data: model[int'(a)], err: 1'b0});
    else             rd_q.push_back('{data: '0, err: 1'b1});
    @(negedge CLK);
    r = rd_q.pop_front();
    checks++;
    if (RD_ACK !== 1'b1) begin
      errors++; $display("FAIL rd_ack a=%0d got %b want 1", a, RD_ACK);
    end
    checks++;
    if (RD_DATA !== r.data || RD_ERR !== r.err) begin
      errors++;
      $display("FAIL rd_data a=%0d got %h/%b want %h/%b", a, RD_DATA, RD_ERR, r.data, r.err);
    end
    repeat (hold) begin
      @(negedge CLK);
      checks++;
      if (RD_ACK !== 1'b1) begin
        errors++; $display("FAIL rd_hold a=%0d got %b want 1", a, RD_ACK);
      end
    end
    #1;
    RD_REQ = 1'b0;
    @(negedge CLK);
    checks++;
    if (RD_ACK !== 1'b0 || RD_ERR !== 1'b0 || RD_DATA !== r.data) begin
      errors++;
      $display("FAIL rd_release a=%0d ack %b err %b data %h want 0/0/%h", a, RD_ACK, RD_ERR, RD_DATA, r.data);
    end
  endtask

  task automatic test_reset;
    model_reset();
    @(negedge CLK);
    checks++;
    if (ent(5) !== DW'(5)) begin
      errors++; $display("FAIL reset_ro5 got %h want 5", ent(5));
    end
    checks++;
    if (d0_dout[5*DW +: DW] !== '0) begin
      errors++; $display("FAIL reset_rw5 got %h want 0", d0_dout[5*DW +: DW]);
    end
    checks++;
    if ({WR_ACK, WR_ERR, RD_ACK, RD_ERR} !== 4'b0 || LOAD_PULSE !== '0 ||
        RD_DATA !== '0 || d0_load_pulse !== '0) begin
      errors++;
      $display("FAIL reset_outs got ack/err %b%b%b%b pulse %h rd %h want 0",
               WR_ACK, WR_ERR, RD_ACK, RD_ERR, LOAD_PULSE, RD_DATA);
    end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_write;
    do_write(8'd3, 20'hABCDE, 3);
    do_read(8'd3, 1);
  endtask

  task automatic test_errors;
    do_write(8'd5, 20'h01234, 0);
    do_write(8'd128, 20'h05678, 1);
    do_write(8'd127, 20'hFFFFF, 0);
    do_read(8'd200, 0);
    do_read(8'd5, 0);
    do_read(8'd127, 0);
    do_write(8'd127, 20'hFFFFF, 0);
  endtask

  task automatic test_same_edge;
    do_write(8'd7, 20'h00011, 0);
    fork
      do_write(8'd7, 20'h00022, 0);
      do_read(8'd7, 0);
    join
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    WR_REQ = 1'b1; WR_ADDR = 8'd9; WR_DATA = 20'h3;
    @(negedge CLK);
    exp_pulses++;
    checks++;
    if (WR_ACK !== 1'b1 || ent(9) !== 20'h3) begin
      errors++; $display("FAIL rst_mid_pre ack %b e9 %h want 1/3", WR_ACK, ent(9));
    end
    #2 RESET = 1'b1;
    #1;
    model_reset();
    checks++;
    if (WR_ACK !== 1'b0 || ent(9) !== '0 || LOAD_PULSE !== '0) begin
      errors++; $display("FAIL rst_mid_async ack %b e9 %h want 0/0", WR_ACK, ent(9));
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    model[9] = 20'h3;
    exp_pulses++;
    checks++;
    if (WR_ACK !== 1'b1 || ent(9) !== 20'h3 || LOAD_PULSE[9] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_reexec ack %b e9 %h p %b want 1/3/1", WR_ACK, ent(9), LOAD_PULSE[9]);
    end
    WR_REQ = 1'b0;
    @(negedge CLK);
    checks++;
    if (WR_ACK !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release got %b want 0", WR_ACK);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    fork
      begin
        repeat (60)
          do_write(8'($urandom_range(0, 135)), 20'($urandom),
                   int'($urandom_range(0, 2)));
      end
      begin
        repeat (60)
          do_read(8'($urandom_range(0, 135)), int'($urandom_range(0, 2)));
      end
    join
    bad = 0;
    for (int i = 0; i < D; i++) begin
      checks++;
      if (ent(i) !== model[i]) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL final_entry %0d got %h want %h", i, ent(i), model[i]);
      end
    end
    checks++;
    if (pulse_cnt !== exp_pulses) begin
      errors++; $display("FAIL pulse_count got %0d want %0d", pulse_cnt, exp_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_errors();
    test_same_edge();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc_rf_bank.md
# lc_rf_bank

Synthesisable, clocked layer-controller register file for MBus layers, replacing the simulation-only LOAD-strobed register array. A requester performs single-register writes and reads over two independent four-phase REQ/ACK ports. Per-entry read-only masking provides built-in sensor-ROM content. Out-of-range and protected accesses are flagged, and a per-register update pulse is emitted. It sits between the MBus layer-controller command decoder and the layer's analog/sensor configuration bits, which consume the flat DOUT bus.

## Interface
Parameters:
- RF_DEPTH, 128: number of registers; 1..2^ADDR_WIDTH.
- DATA_WIDTH, `LC_RF_DATA_WIDTH: register width in bits.
- ADDR_WIDTH, 8: width of WR_ADDR and RD_ADDR.
- RO_MASK, all zeros, RF_DEPTH bits: bit i = 1 makes entry i read-only, holding constant i (zero-extended or truncated to DATA_WIDTH).

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  sole clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- WR_REQ  in  1  write request; held high until WR_ACK is seen.
- WR_ADDR  in  ADDR_WIDTH  write address; stable while WR_REQ is high.
- WR_DATA  in  DATA_WIDTH  write data; stable while WR_REQ is high.
- WR_ACK  out  1  write acknowledge.
- WR_ERR  out  1  write rejected; valid while WR_ACK is high.
- RD_REQ  in  1  read request.
- RD_ADDR  in  ADDR_WIDTH  read address.
- RD_ACK  out  1  read acknowledge.
- RD_DATA  out  DATA_WIDTH  read data; valid while RD_ACK is high.
- RD_ERR  out  1  read rejected; valid while RD_ACK is high.
- DOUT  out  DATA_WIDTH*RF_DEPTH  flat contents; entry i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- LOAD_PULSE  out  RF_DEPTH  one-cycle pulse on bit i when entry i is written.

## Operation
Reset (asynchronous, immediate):
- RW entries = 0; RO entries = index.
- WR_ACK, WR_ERR, RD_ACK, RD_ERR, RD_DATA and LOAD_PULSE all = 0.
- Both port FSMs go to IDLE.

Each port runs its own two-state FSM, IDLE and ACK:
- IDLE -> ACK: REQ sampled high. The access executes on that same edge.
- ACK -> IDLE: REQ sampled low. ACK and ERR clear on that edge.
- In ACK, REQ held high causes no re-execution.

Write execution:
- Address in range (WR_ADDR < RF_DEPTH) and not RO: the entry takes WR_DATA, the LOAD_PULSE bit is set, WR_ERR = 0.
- Address out of range or RO: no state change, no pulse, WR_ERR = 1.

Read execution:
- Address in range: RD_DATA = entry value, RD_ERR = 0.
- Address out of range: RD_DATA = 0, RD_ERR = 1.
- RD_DATA holds its value until the next read executes.

Boundary conditions:
- A write and a read to the same address executing on the same edge: the read returns the pre-write value.
- The two ports are fully concurrent; there is no arbitration.
- Writing the value an entry already holds still pulses LOAD_PULSE.
- Address RF_DEPTH-1 is valid; address RF_DEPTH is an error. No wrap-around.
- RESET asserted mid-handshake aborts the access. ACK drops immediately and an unexecuted write is lost. A requester still holding REQ after RESET is released is served as a new request.

## Timing
- Edge k samples REQ = 1 in IDLE: the outputs below are visible after edge k. Latency from sampled REQ is one edge.
  - Entry update.
  - LOAD_PULSE.
  - ACK, ERR and RD_DATA.
- LOAD_PULSE is high for exactly one cycle and clears at edge k+1.
- ACK stays high until the first edge that samples REQ = 0, then clears on that edge.
- The earliest next execution is the edge after that.
- Minimum full handshake is 3 edges.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package holds:
  - FSM state encodings IDLE and ACK.
  - The default DATA_WIDTH, taken from `LC_RF_DATA_WIDTH.
- Elaboration check: 2^ADDR_WIDTH >= RF_DEPTH.
- Sub-module lc_rf_hs_port holds the two-state REQ/ACK FSM plus the execute strobe. It is instantiated once for the write port and once for the read port.
- The top level contains the register array, RO generation, error decode and DOUT packing.

## Test plan
- Reset then idle: DOUT entry 5 = 0 with RO_MASK = 0; with RO_MASK bit 5 set, entry 5 = 5; all ACK/ERR/LOAD_PULSE = 0.
- Write addr 3, data 0xABCDE; hold REQ 4 cycles: DOUT entry 3 = 0xABCDE one edge after REQ is sampled; LOAD_PULSE[3] high for exactly 1 cycle; WR_ACK high until REQ is sampled low; WR_ERR = 0.
- Write addr 5 (RO) and write addr 128 (RF_DEPTH = 128): WR_ERR = 1, DOUT unchanged, no LOAD_PULSE. Read addr 200: RD_DATA = 0, RD_ERR = 1.
- Entry 7 holds 0x11; write addr 7 = 0x22 and read addr 7 executing on the same edge: RD_DATA = 0x11; DOUT entry 7 = 0x22.
- Assert RESET while WR_ACK is high after writing addr 9 = 0x3: WR_ACK drops asynchronously; entry 9 = 0 after reset. REQ still high after release: the write re-executes.
- Random back-to-back four-phase traffic on both ports against a reference model: no lost or duplicated writes; each write gives exactly one LOAD_PULSE.
